// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that time-shares one 4:1 mux between NUM_REQ requesters.
// A grant is held while its owner keeps requesting, but for no more than
// MAX_HOLD consecutive cycles when anyone else is waiting. If nobody else is
// waiting, the grant is renewed without a gap. All outputs come straight from
// flops, so sel_out can drive the mux select without glitches.
module mux_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2,
  parameter int MAX_HOLD  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_REQ-1:0]   req_in,
  output logic [NUM_REQ-1:0]   gnt_out,
  output logic [SEL_WIDTH-1:0] sel_out,
  output logic                 valid_out
);

  // A counter of at least one bit keeps MAX_HOLD == 1 legal.
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // Reject configurations where the select cannot address every requester.
  if (NUM_REQ != 2 ** SEL_WIDTH) begin : g_bad_num_req
    $error("mux_rr_arbiter: NUM_REQ must equal 2**SEL_WIDTH");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_reg;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic [SEL_WIDTH-1:0] sel_reg;
  logic [SEL_WIDTH-1:0] ptr_reg;
  logic [HOLD_W-1:0]    hold_reg;
  logic                 valid_reg;

  // Search the mask starting at index start. Indices wrap naturally because
  // NUM_REQ is a power of two. The loop runs downward so that the smallest
  // offset from start is the one that is kept.
  function automatic logic [SEL_WIDTH-1:0] pick(input logic [NUM_REQ-1:0]   mask,
                                                input logic [SEL_WIDTH-1:0] start);
    logic [SEL_WIDTH-1:0] idx;
    logic [SEL_WIDTH-1:0] res;
    res = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + SEL_WIDTH'(i);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [SEL_WIDTH-1:0] sel_inc;
  logic [NUM_REQ-1:0]   others;
  logic                 has_others;
  logic                 owner_req;
  logic [SEL_WIDTH-1:0] idle_pick;
  logic [SEL_WIDTH-1:0] next_pick;

  // Arbitration candidates. The owner is always excluded from the handoff
  // search. On a release the owner's bit is already low, so one search
  // covers both the release case and the expiry case.
  always_comb begin
    sel_inc    = sel_reg + SEL_WIDTH'(1);
    others     = req_in & ~onehot(sel_reg);
    has_others = |others;
    owner_req  = req_in[sel_reg];
    idle_pick  = pick(req_in, ptr_reg);
    next_pick  = pick(others, sel_inc);
  end

  // Arbiter FSM: the owner, pointer, hold counter and all outputs are registered.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      hold_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_in) begin
            state_reg <= GRANT;
            gnt_reg   <= onehot(idle_pick);
            sel_reg   <= idle_pick;
            hold_reg  <= '0;
            valid_reg <= 1'b1;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            // Release: the pointer moves past the departing owner.
            ptr_reg  <= sel_inc;
            hold_reg <= '0;
            if (has_others) begin
              gnt_reg <= onehot(next_pick);
              sel_reg <= next_pick;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
              valid_reg <= 1'b0;
            end
          end else if (hold_reg != HOLD_LAST) begin
            hold_reg <= hold_reg + HOLD_W'(1);
          end else begin
            // Expiry: hand off if anyone else waits, otherwise renew in place.
            hold_reg <= '0;
            if (has_others) begin
              ptr_reg <= sel_inc;
              gnt_reg <= onehot(next_pick);
              sel_reg <= next_pick;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_out   = gnt_reg;
  assign sel_out   = sel_reg;
  assign valid_out = valid_reg;

  // Invariants on the registered outputs.
  a_gnt_onehot0: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    $onehot0(gnt_reg));
  a_sel_matches: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    valid_reg |-> gnt_reg[sel_reg]);
  a_valid_or: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    valid_reg == (|gnt_reg));
  a_gnt_requested: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (gnt_reg & ~$past(req_in)) == '0);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter. Directed scenarios are checked
// against literal expected values. A randomized run is checked against a
// cycle-level model that tracks the owner, the pointer and the run length.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int H = 8;

  logic       clk;
  logic       rst_n_in;
  logic [3:0] req_in;
  logic [3:0] gnt_out;
  logic [1:0] sel_out;
  logic       valid_out;

  int checks   = 0;
  int failures = 0;

  // Model state: m_owner is -1 when idle. m_run counts the consecutive cycles
  // granted in the current tenure, including the present cycle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_run   = 0;
  int m_sel   = 0;

  mux_rr_arbiter #(.NUM_REQ(N), .SEL_WIDTH(2), .MAX_HOLD(H)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n_in),
    .req_in   (req_in),
    .gnt_out  (gnt_out),
    .sel_out  (sel_out),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_pick(input logic [3:0] mask, input int start);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Apply one edge to the reference model.
  task automatic model_edge(input logic [3:0] r, input logic rs);
    logic [3:0] others;
    if (!rs) begin
      m_owner = -1; m_ptr = 0; m_run = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      if (r != 4'b0) begin
        m_owner = m_pick(r, m_ptr); m_run = 1; m_sel = m_owner;
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % N;
      if (r != 4'b0) begin
        m_owner = m_pick(r, m_ptr); m_run = 1; m_sel = m_owner;
      end else begin
        m_owner = -1; m_run = 0;
      end
    end else if (m_run < H) begin
      m_run = m_run + 1;
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      m_run = 1;
      if (others != 4'b0) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = m_pick(others, m_ptr); m_sel = m_owner;
      end
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, then settle past the edge.
  task automatic step(input logic [3:0] r, input logic rs);
    req_in   = r;
    rst_n_in = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, 1'b0);
      checks++;
      if (gnt_out !== 4'b0 || sel_out !== 2'd0 || valid_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold gnt=%b/0000 sel=%0d/0 valid=%b/0", gnt_out, sel_out, valid_out);
      end
    end
    step(4'b1111, 1'b1);
    checks++;
    if (gnt_out !== 4'b0001 || sel_out !== 2'd0 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_release gnt=%b/0001 sel=%0d/0 valid=%b/1", gnt_out, sel_out, valid_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, 1'b1);
      checks++;
      if (gnt_out !== 4'b0100 || sel_out !== 2'd2 || valid_out !== 1'b1) begin
        failures++;
        $display("FAIL single_hold cyc=%0d gnt=%b/0100 sel=%0d/2 valid=%b/1", i, gnt_out, sel_out, valid_out);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(4'b0000, 1'b1);
      checks++;
      if (gnt_out !== 4'b0 || sel_out !== 2'd2 || valid_out !== 1'b0) begin
        failures++;
        $display("FAIL single_drop cyc=%0d gnt=%b/0000 sel=%0d/2 valid=%b/0", i, gnt_out, sel_out, valid_out);
      end
    end
    $display("test_single done");
  endtask

  task automatic test_contention();
    logic [3:0] one;
    logic [3:0] exp_g;
    int o;
    one = 4'b0001;
    do_reset();
    for (int k = 0; k < 4 * H + 1; k++) begin
      step(4'b1111, 1'b1);
      o = (k / H) % N;
      exp_g = one << o;
      checks++;
      if (gnt_out !== exp_g || sel_out !== 2'(o) || valid_out !== 1'b1) begin
        failures++;
        $display("FAIL contention cyc=%0d gnt=%b/%b sel=%0d/%0d valid=%b/1", k, gnt_out, exp_g, sel_out, o, valid_out);
      end
    end
    $display("test_contention done");
  endtask

  task automatic test_early_release();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 1'b1);
      checks++;
      if (gnt_out !== 4'b0010 || sel_out !== 2'd1) begin
        failures++;
        $display("FAIL early_owner1 cyc=%0d gnt=%b/0010 sel=%0d/1", i, gnt_out, sel_out);
      end
    end
    step(4'b1000, 1'b1);
    checks++;
    if (gnt_out !== 4'b1000 || sel_out !== 2'd3 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL early_handoff gnt=%b/1000 sel=%0d/3 valid=%b/1", gnt_out, sel_out, valid_out);
    end
    for (int i = 1; i < H; i++) begin
      step(4'b1001, 1'b1);
      checks++;
      if (gnt_out !== 4'b1000 || sel_out !== 2'd3) begin
        failures++;
        $display("FAIL early_restart cyc=%0d gnt=%b/1000 sel=%0d/3", i, gnt_out, sel_out);
      end
    end
    step(4'b1001, 1'b1);
    checks++;
    if (gnt_out !== 4'b0001 || sel_out !== 2'd0) begin
      failures++;
      $display("FAIL early_expiry gnt=%b/0001 sel=%0d/0", gnt_out, sel_out);
    end
    $display("test_early_release done");
  endtask

  task automatic test_wrap();
    do_reset();
    step(4'b1000, 1'b1);
    checks++;
    if (gnt_out !== 4'b1000 || sel_out !== 2'd3) begin
      failures++;
      $display("FAIL wrap_owner3 gnt=%b/1000 sel=%0d/3", gnt_out, sel_out);
    end
    step(4'b0011, 1'b1);
    checks++;
    if (gnt_out !== 4'b0001 || sel_out !== 2'd0 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL wrap_handoff gnt=%b/0001 sel=%0d/0 valid=%b/1", gnt_out, sel_out, valid_out);
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b1111, 1'b1);
    checks++;
    if (gnt_out !== 4'b0100 || sel_out !== 2'd2) begin
      failures++;
      $display("FAIL midrst_setup gnt=%b/0100 sel=%0d/2", gnt_out, sel_out);
    end
    step(4'b1111, 1'b0);
    checks++;
    if (gnt_out !== 4'b0 || sel_out !== 2'd0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear gnt=%b/0000 sel=%0d/0 valid=%b/0", gnt_out, sel_out, valid_out);
    end
    step(4'b1111, 1'b1);
    checks++;
    if (gnt_out !== 4'b0001 || sel_out !== 2'd0 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ptr gnt=%b/0001 sel=%0d/0 valid=%b/1", gnt_out, sel_out, valid_out);
    end
    $display("test_reset_mid_grant done");
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] one;
    logic [3:0] exp_g;
    logic       rs;
    int         errs;
    one  = 4'b0001;
    errs = 0;
    do_reset();
    r = 4'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 79) != 0);
      step(r, rs);
      exp_g = (m_owner < 0) ? 4'b0 : (one << m_owner);
      checks++;
      if (gnt_out !== exp_g || sel_out !== 2'(m_sel) || valid_out !== (m_owner >= 0)) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc=%0d req=%b gnt=%b/%b sel=%0d/%0d valid=%b/%b",
                   i, r, gnt_out, exp_g, sel_out, m_sel, valid_out, (m_owner >= 0));
      end
    end
    $display("test_random done");
  endtask

  initial begin
    req_in   = 4'b0;
    rst_n_in = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_wrap();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux (built from cascaded 2:1 muxes) between NUM_REQ requesters.
- Drives the mux select (sel_out goes straight to the mux sel_in) plus a one-hot grant back to the requesters.
- Each grant is held for at most MAX_HOLD cycles while others wait, so no requester is starved.
- All outputs are registered, so the mux select is glitch-free.

Parameters:
- NUM_REQ, 4, number of requesters; must equal 2**SEL_WIDTH.
- SEL_WIDTH, 2, width of the mux select.
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner when others are requesting; must be at least 1.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  synchronous active-low reset.
- req_in  input  NUM_REQ  request vector, bit i = requester i.
- gnt_out  output  NUM_REQ  one-hot grant, or all-zero when idle.
- sel_out  output  SEL_WIDTH  binary index of the owner; drives the mux sel_in.
- valid_out  output  1  high while a grant is active (equals |gnt_out).

Behaviour:
- Reset, sampled on a clock edge with rst_n_in low:
  - state = IDLE, gnt_out = 0, sel_out = 0, valid_out = 0.
  - Round-robin pointer ptr = 0 (requester 0 has highest priority).
  - hold_cnt = 0.
  - Reset overrides all other activity, including mid-grant.
- Arbitration function pick(mask, start): the first set bit of mask, searching start, start+1, ... modulo NUM_REQ.
- State IDLE:
  - req_in == 0: remain IDLE; gnt_out stays 0; sel_out holds its last value.
  - req_in != 0: owner = pick(req_in, ptr) → state GRANT, gnt_out = onehot(owner), sel_out = owner, valid_out = 1, hold_cnt = 0.
  - Latency: gnt_out is high in the cycle after the edge that first sampled the request.
- State GRANT, evaluated each edge with owner o:
  - Release (req_in[o] == 0):
    - ptr = o+1 mod NUM_REQ.
    - If req_in has other bits set: owner = pick(req_in, o+1), with no idle cycle (direct handoff), hold_cnt = 0.
    - Otherwise → IDLE: gnt_out = 0, valid_out = 0, sel_out holds o.
  - Hold (req_in[o] == 1, hold_cnt < MAX_HOLD-1): stay on o, hold_cnt += 1.
  - Expiry (req_in[o] == 1, hold_cnt == MAX_HOLD-1):
    - Others requesting: owner = pick(req_in & ~onehot(o), o+1), ptr = o+1, hold_cnt = 0.
    - None requesting: keep o, hold_cnt = 0 (renewal; gnt_out stays continuously high).
- Consequences:
  - Under contention an owner sees gnt_out high for exactly MAX_HOLD consecutive cycles.
  - gnt_out drops one cycle after the owner deasserts its request, because outputs are registered.
  - Requests arriving or leaving on the same edge as a release or expiry are arbitrated on that edge using the sampled req_in.
- Wrap-around: the pointer and search wrap from NUM_REQ-1 to 0.
- hold_cnt width: clog2(MAX_HOLD); it never exceeds MAX_HOLD-1.
- Invariants (assertions):
  - gnt_out is one-hot or zero.
  - When valid_out = 1, gnt_out[sel_out] == 1.
  - valid_out == |gnt_out.
  - No grant to a requester whose request was low at the granting edge.
- Elaboration error if NUM_REQ != 2**SEL_WIDTH or MAX_HOLD < 1.

Test Plan:
- Reset: req_in = 4'b1111 while rst_n_in is low for 2 cycles → gnt_out = 0, sel_out = 0, valid_out = 0; first cycle after release gnt_out = 4'b0001, sel_out = 0.
- Single requester: req_in = 4'b0100 from IDLE, held 20 cycles → gnt_out = 4'b0100, sel_out = 2 from the next cycle, continuously high across renewals; drop req → gnt_out = 0 one cycle later, sel_out stays 2.
- Full contention: req_in = 4'b1111 constant, MAX_HOLD = 8 → gnt_out = 0001 ×8, 0010 ×8, 0100 ×8, 1000 ×8, then 0001; sel_out = 0, 1, 2, 3, 0; valid_out never drops.
- Early release handoff: owner 1 (req_in = 4'b1010) drops bit 1 after 3 grant cycles → next cycle gnt_out = 4'b1000, sel_out = 3, no idle cycle, hold_cnt restarted (8 more cycles).
- Wrap-around: owner 3 releases with req_in = 4'b0011 → gnt_out = 4'b0001, sel_out = 0.
- Reset mid-grant: rst_n_in low for 1 cycle while gnt_out = 4'b0100 and req_in = 4'b1111 → outputs zero the next cycle; after release gnt_out = 4'b0001, confirming ptr was reset.
